// File: rtl/read_prefetch_buffer_if.sv
// Valid/ready word stream used on both sides of the read prefetch buffer.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface read_prefetch_buffer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/read_prefetch_buffer.sv
// Multi-entry read prefetch buffer between the FIFO RAM read port and the consumer.
// It is a circular store of DEPTH words with first-word fall-through. Full and empty
// are told apart by the occupancy count rather than by comparing the pointers.
// It also provides a synchronous flush and a sticky overflow flag.
module read_prefetch_buffer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AEMPTY_TH = 1
) (
  input  logic                     clk,
  input  logic                     Clear,
  input  logic                     flush,
  read_prefetch_buffer_if.slave    inIf,
  read_prefetch_buffer_if.master   outIf,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_empty,
  output logic                     overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AE_LIMIT   = CW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic inReady;
  logic outValid;
  logic push;
  logic pop;

  // Decode the handshakes from the registered count and work out the next pointer, count and flag state.
  // Flush overrides any same-cycle push or pop. A rejected push only raises the sticky flag.
  always_comb begin
    inReady    = (count_q != FULL_COUNT);
    outValid   = (count_q != '0);
    push       = inIf.valid & inReady & ~flush;
    pop        = outValid & outIf.ready & ~flush;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)  rdPtr_d = rdPtr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
    if (inIf.valid && !inReady && !flush) overflow_d = 1'b1;
  end

  // Pointer, count and overflow registers; Clear empties the buffer immediately.
  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Word storage has no reset, because the head output is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q] <= inIf.data;
  end

  assign inIf.ready   = inReady;
  assign outIf.valid  = outValid;
  assign outIf.data   = outValid ? mem[rdPtr_q] : '0;
  assign count        = count_q;
  assign almost_empty = (count_q <= AE_LIMIT);
  assign overflow_err = overflow_q;

endmodule
